sha256_padder: RTL



---
 rtl/sha256_padder_if.sv | 23 ++
 rtl/sha256_padder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sha256_padder_if.sv
// sha256_padder_if: byte-stream input and padded-block output bundle.
//   master : message source / core side (drives in_valid, in_data, in_last)
//   slave  : sha256_padder (drives in_ready, load, message_8, busy, err)
interface sha256_padder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       load;
  logic [7:0] message_8;
  logic       busy;
  logic       err;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, load, message_8, busy, err
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, load, message_8, busy, err
  );
endinterface

// File: rtl/sha256_padder.sv
// sha256_padder: buffers a 1..55 byte message, then streams the padded
// 64-byte SHA-256 block one byte per clock, then holds off HOLDOFF cycles.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   bus (slave)   in_valid/in_data/in_last/in_ready byte stream in,
//                 load/message_8 block out, busy, err
// Parameter HOLDOFF (1..255): idle cycles after block byte 63.
// Build option SHA256_PAD_ERR_EN: when defined, an over-long message is
// dropped and flagged on err; otherwise it is truncated to 55 bytes.
module sha256_padder #(
  parameter int unsigned HOLDOFF = 80
) (
  input  logic            clk,
  input  logic            rst,
  sha256_padder_if.slave  bus
);

  localparam int unsigned MAX_LEN  = 55;
  localparam int unsigned LEN_W    = 6;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned BITLEN_W = 11;

  typedef enum logic [1:0] {FILL, SEND, HOLD} state_t;

  state_t             r_state;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_buf [MAX_LEN];
  logic               r_load;
  logic [7:0]         r_msg;
  logic               r_busy;
  logic               r_err;
`ifdef SHA256_PAD_ERR_EN
  logic               r_drop;
`endif

  logic                w_in_ready;
  logic                w_accept;
  logic                w_full;
  logic [BITLEN_W-1:0] w_bitlen;
  logic [7:0]          w_byte;

  // Ready is combinational so it drops the instant rst is raised.
  assign w_in_ready = !rst && (r_state == FILL);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_full     = (r_len == LEN_W'(MAX_LEN));
  assign w_bitlen   = {2'b00, r_len, 3'b000};

  // Padded block byte at position r_idx.
  always_comb begin
    w_byte = 8'h00;
    if (r_idx < r_len) begin
      w_byte = r_buf[r_idx];
    end else if (r_idx == r_len) begin
      w_byte = 8'h80;
    end else if (r_idx == LEN_W'(62)) begin
      w_byte = {5'b00000, w_bitlen[10:8]};
    end else if (r_idx == LEN_W'(63)) begin
      w_byte = w_bitlen[7:0];
    end
  end

  // FILL -> SEND -> HOLD control with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_len   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_load  <= 1'b0;
      r_msg   <= 8'h00;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
`ifdef SHA256_PAD_ERR_EN
      r_drop  <= 1'b0;
`endif
    end else begin
      r_load <= 1'b0;
      r_msg  <= 8'h00;
      r_err  <= 1'b0;
      case (r_state)
        FILL: begin
          r_busy <= 1'b0;
          if (w_accept) begin
`ifdef SHA256_PAD_ERR_EN
            // Once the 56th byte arrives, swallow the rest of the message.
            if (r_drop || w_full) begin
              if (bus.in_last) begin
                r_err  <= 1'b1;
                r_len  <= '0;
                r_drop <= 1'b0;
              end else begin
                r_drop <= 1'b1;
              end
            end else begin
              r_buf[r_len] <= bus.in_data;
              r_len        <= r_len + LEN_W'(1);
              if (bus.in_last) begin
                r_state <= SEND;
                r_idx   <= '0;
              end
            end
`else
            // Bytes past 55 are discarded; the block is sent truncated.
            if (!w_full) begin
              r_buf[r_len] <= bus.in_data;
              r_len        <= r_len + LEN_W'(1);
            end
            if (bus.in_last) begin
              r_state <= SEND;
              r_idx   <= '0;
            end
`endif
          end
        end
        SEND: begin
          r_busy <= 1'b1;
          r_load <= (r_idx == '0);
          r_msg  <= w_byte;
          r_idx  <= r_idx + LEN_W'(1);
          if (r_idx == LEN_W'(63)) begin
            r_state <= HOLD;
            r_cnt   <= CNT_W'(HOLDOFF);
          end
        end
        HOLD: begin
          // Counter runs HOLDOFF..0 so FILL returns after HOLDOFF idle
          // cycles following the byte-63 window.
          if (r_cnt == '0) begin
            r_state <= FILL;
            r_len   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_busy <= 1'b1;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.load      = r_load;
  assign bus.message_8 = r_msg;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

endmodule
